reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/core_pkg.sv | 26 ++
 rtl/reorder_buffer.sv | 125 ++++++++++++
 tb/tb_reorder_buffer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Purpose  : Shared core types and sizing constants for the reorder buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

   localparam int ROB_ENTRIES  = 16;
   localparam int RETIRE_WIDTH = 2;

   typedef struct packed {
      logic [4:0]  dest_reg;
      logic        wb_en;
      logic [31:0] pc;
      logic        mispred;
      logic        exception;
   } rob_entry_t;

   typedef struct packed {
      logic valid;
      logic ready;
   } rob_status_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Purpose  : Circular in-order retire buffer with multi-wide retire and flush.
//  Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer
   import core_pkg::*;
#(
   parameter int ROB_ENTRIES  = core_pkg::ROB_ENTRIES,
   parameter int RETIRE_WIDTH = core_pkg::RETIRE_WIDTH
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   alloc_valid,
   input  rob_entry_t                             alloc_entry,
   output logic                                   alloc_ready,
   output logic [$clog2(ROB_ENTRIES)-1:0]         alloc_idx,
   input  logic                                   cmpl_valid,
   input  logic [$clog2(ROB_ENTRIES)-1:0]         cmpl_idx,
   input  logic [31:0]                            cmpl_result,
   input  logic                                   cmpl_mispred,
   input  logic                                   cmpl_exception,
   output logic [RETIRE_WIDTH-1:0]                retire_valid,
   output rob_entry_t [RETIRE_WIDTH-1:0]          retire_entry,
   output logic [RETIRE_WIDTH-1:0][31:0]          retire_result,
   output logic                                   flush,
   output logic [31:0]                            flush_pc,
   output logic [$clog2(ROB_ENTRIES):0]           count,
   output logic                                   empty
);

   localparam int            IW      = $clog2(ROB_ENTRIES);
   localparam int            CW      = IW + 1;
   localparam logic [CW-1:0] c_depth = CW'(ROB_ENTRIES);

   logic [IW-1:0] r_head;
   logic [IW-1:0] r_tail;
   logic [CW-1:0] r_count;
   rob_status_t   r_status [ROB_ENTRIES];
   rob_entry_t    r_entry  [ROB_ENTRIES];
   logic [31:0]   r_result [ROB_ENTRIES];

   logic [RETIRE_WIDTH-1:0] w_ret;
   logic [CW-1:0]           w_ret_cnt;
   logic [IW-1:0]           w_slot_idx [RETIRE_WIDTH];
   logic                    w_flush;
   logic                    w_alloc_fire;
   logic                    w_cmpl_fire;

   // Only slot 0 may carry a mispredict/exception, so the flush always
   // coincides with that entry being the oldest one retiring.
   always_comb begin
      logic v_chain;
      logic v_clean;
      w_ret         = '0;
      w_ret_cnt     = '0;
      retire_entry  = '0;
      retire_result = '0;
      v_chain       = !rst;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         w_slot_idx[i]    = r_head + IW'(i);
         v_clean          = !r_entry[w_slot_idx[i]].mispred && !r_entry[w_slot_idx[i]].exception;
         w_ret[i]         = v_chain && r_status[w_slot_idx[i]].valid && r_status[w_slot_idx[i]].ready
                            && ((i == 0) || v_clean);
         v_chain          = w_ret[i] && v_clean;
         w_ret_cnt        = w_ret_cnt + CW'(w_ret[i]);
         retire_entry[i]  = r_entry[w_slot_idx[i]];
         retire_result[i] = r_result[w_slot_idx[i]];
      end
      retire_entry[0].wb_en = r_entry[r_head].wb_en && !r_entry[r_head].exception;
   end

   assign w_flush      = w_ret[0] && (r_entry[r_head].mispred || r_entry[r_head].exception);
   assign w_alloc_fire = alloc_valid && alloc_ready && !rst;
   assign w_cmpl_fire  = cmpl_valid && r_status[cmpl_idx].valid && !w_flush;

   assign retire_valid = w_ret;
   assign flush        = w_flush;
   assign flush_pc     = w_flush ? r_entry[r_head].pc : 32'h0;
   assign alloc_ready  = rst || ((r_count < c_depth) && !w_flush);
   assign alloc_idx    = rst ? '0 : r_tail;
   assign count        = rst ? '0 : r_count;
   assign empty        = (count == '0);

   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < ROB_ENTRIES; i++) begin
            r_status[i] <= '0;
         end
      end else begin
         if (w_cmpl_fire) begin
            r_status[cmpl_idx].ready <= 1'b1;
         end
         for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (w_ret[i]) begin
               r_status[w_slot_idx[i]] <= '0;
            end
         end
         if (w_alloc_fire) begin
            r_status[r_tail] <= '{valid: 1'b1, ready: 1'b0};
         end
         r_head  <= r_head + IW'(w_ret_cnt);
         r_tail  <= r_tail + IW'(w_alloc_fire);
         r_count <= r_count + CW'(w_alloc_fire) - w_ret_cnt;
      end
   end

   // Payload is qualified by the status bits, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_alloc_fire) begin
         r_entry[r_tail] <= alloc_entry;
      end
      if (w_cmpl_fire) begin
         r_result[cmpl_idx]          <= cmpl_result;
         r_entry[cmpl_idx].mispred   <= r_entry[cmpl_idx].mispred   | cmpl_mispred;
         r_entry[cmpl_idx].exception <= r_entry[cmpl_idx].exception | cmpl_exception;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reorder_buffer
//  Purpose  : Directed stimulus with a retire scoreboard for reorder_buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reorder_buffer;
   import core_pkg::*;

   localparam int          N  = 16;
   localparam int          RW = 2;
   localparam logic [31:0] K  = 32'h5A5A_0000;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  alloc_valid;
   rob_entry_t            alloc_entry;
   logic                  alloc_ready;
   logic [3:0]            alloc_idx;
   logic                  cmpl_valid;
   logic [3:0]            cmpl_idx;
   logic [31:0]           cmpl_result;
   logic                  cmpl_mispred;
   logic                  cmpl_exception;
   logic [RW-1:0]         retire_valid;
   rob_entry_t [RW-1:0]   retire_entry;
   logic [RW-1:0][31:0]   retire_result;
   logic                  flush;
   logic [31:0]           flush_pc;
   logic [4:0]            count;
   logic                  empty;

   always #5 clk = ~clk;

   reorder_buffer #(.ROB_ENTRIES(N), .RETIRE_WIDTH(RW)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_entry(alloc_entry),
      .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
      .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_result(cmpl_result),
      .cmpl_mispred(cmpl_mispred), .cmpl_exception(cmpl_exception),
      .retire_valid(retire_valid), .retire_entry(retire_entry),
      .retire_result(retire_result), .flush(flush), .flush_pc(flush_pc),
      .count(count), .empty(empty)
   );

   typedef struct {
      logic [4:0]  dest;
      logic        wb_en;
      logic [31:0] pc;
      logic [31:0] result;
      logic        flush;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] tb_pc [N];
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every retired slot must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst) begin
         for (int s = 0; s < RW; s++) begin
            if (retire_valid[s]) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_retire: slot %0d pc 0x%0h with nothing expected", s, retire_entry[s].pc);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("retire_pc", retire_entry[s].pc, e.pc);
                  chk("retire_result", retire_result[s], e.result);
                  chk("retire_dest_wb", {retire_entry[s].dest_reg, retire_entry[s].wb_en}, {e.dest, e.wb_en});
                  if (s == 0) begin
                     chk("retire_flush", flush, e.flush);
                     chk("retire_flush_pc", flush_pc, e.flush ? e.pc : 32'h0);
                  end
               end
            end
         end
         if (flush && !retire_valid[0]) begin
            checks++;
            failures++;
            $display("FAIL flush_without_retire: got flush=1 required 0");
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      alloc_valid    = 1'b0;
      cmpl_valid     = 1'b0;
      cmpl_mispred   = 1'b0;
      cmpl_exception = 1'b0;
   endtask

   task automatic do_alloc(input logic [4:0] dest, input logic wb, input logic [31:0] pc,
                           input logic [3:0] exp_idx, input logic push,
                           input logic exp_wb, input logic exp_flush);
      exp_t e;
      alloc_valid = 1'b1;
      alloc_entry = '{dest_reg: dest, wb_en: wb, pc: pc, mispred: 1'b0, exception: 1'b0};
      tb_pc[exp_idx] = pc;
      if (push) begin
         e = '{dest: dest, wb_en: exp_wb, pc: pc, result: pc ^ K, flush: exp_flush};
         sb.push_back(e);
      end
      #1;
      chk("alloc_idx", {28'h0, alloc_idx}, {28'h0, exp_idx});
      chk("alloc_ready", alloc_ready, 1'b1);
   endtask

   task automatic do_cmpl(input logic [3:0] idx, input logic mp, input logic ex);
      cmpl_valid     = 1'b1;
      cmpl_idx       = idx;
      cmpl_result    = tb_pc[idx] ^ K;
      cmpl_mispred   = mp;
      cmpl_exception = ex;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; alloc_valid = 1'b0; alloc_entry = '0;
      cmpl_valid = 1'b0; cmpl_idx = '0; cmpl_result = '0;
      cmpl_mispred = 1'b0; cmpl_exception = 1'b0;
      for (int i = 0; i < N; i++) tb_pc[i] = '0;
      repeat (2) tick();
      #1;
      chk("rst_alloc_ready", alloc_ready, 1'b1);
      chk("rst_alloc_idx", {28'h0, alloc_idx}, 32'h0);
      chk("rst_retire_valid", {30'h0, retire_valid}, 32'h0);
      chk("rst_flush", flush, 1'b0);
      chk("rst_flush_pc", flush_pc, 32'h0);
      chk("rst_count", {27'h0, count}, 32'h0);
      chk("rst_empty", empty, 1'b1);
      rst = 1'b0;
      tick();

      // Fill to capacity, then a dropped 17th allocation
      for (int i = 0; i < N; i++) begin
         do_alloc(5'(i), 1'b1, 32'h1000 + 32'(4 * i), 4'(i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      #1;
      chk("fill_count", {27'h0, count}, 32'd16);
      chk("fill_ready_low", alloc_ready, 1'b0);
      alloc_valid = 1'b1;
      alloc_entry = '{dest_reg: 5'd31, wb_en: 1'b1, pc: 32'hDEAD, mispred: 1'b0, exception: 1'b0};
      tick();
      #1;
      chk("fill_17th_count", {27'h0, count}, 32'd16);
      chk("fill_17th_idx", {28'h0, alloc_idx}, 32'h0);
      do_reset();

      // In-order retire: completions 3,1,0,2
      for (int i = 0; i < 4; i++) begin
         do_alloc(5'(i + 1), 1'b1, 32'h40 + 32'(4 * i), 4'(i), 1'b1, 1'b1, 1'b0);
         tick();
      end
      do_cmpl(4'd3, 1'b0, 1'b0); #1; chk("inorder_wait_a", {30'h0, retire_valid}, 32'h0); tick();
      do_cmpl(4'd1, 1'b0, 1'b0); #1; chk("inorder_wait_b", {30'h0, retire_valid}, 32'h0); tick();
      do_cmpl(4'd0, 1'b0, 1'b0); #1; chk("inorder_wait_c", {30'h0, retire_valid}, 32'h0); tick();
      do_cmpl(4'd2, 1'b0, 1'b0); #1; chk("inorder_pair01", {30'h0, retire_valid}, 32'h3); tick();
      #1; chk("inorder_pair23", {30'h0, retire_valid}, 32'h3); tick();
      #1;
      chk("inorder_count", {27'h0, count}, 32'h0);
      chk("inorder_empty", empty, 1'b1);
      do_reset();

      // Wrap: retire 10, then 10 more allocations across index 15 -> 0
      for (int i = 0; i < 10; i++) begin
         do_alloc(5'(i), 1'b1, 32'h2000 + 32'(4 * i), 4'(i), 1'b1, 1'b1, 1'b0);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         do_cmpl(4'(i), 1'b0, 1'b0);
         tick();
      end
      repeat (2) tick();
      #1;
      chk("wrap_mid_count", {27'h0, count}, 32'h0);
      for (int k = 0; k < 10; k++) begin
         do_alloc(5'(k + 10), 1'b0, 32'h3000 + 32'(4 * k), 4'(10 + k), 1'b1, 1'b0, 1'b0);
         tick();
      end
      for (int k = 0; k < 10; k++) begin
         do_cmpl(4'(3 - k), 1'b0, 1'b0);
         tick();
      end
      repeat (6) tick();
      #1;
      chk("wrap_count", {27'h0, count}, 32'h0);
      chk("wrap_empty", empty, 1'b1);
      do_reset();

      // Mispredict at head with head+1 ready
      do_alloc(5'd7, 1'b1, 32'h100, 4'd0, 1'b1, 1'b1, 1'b1); tick();
      do_alloc(5'd8, 1'b1, 32'h104, 4'd1, 1'b0, 1'b0, 1'b0); tick();
      do_cmpl(4'd1, 1'b0, 1'b0); tick();
      do_cmpl(4'd0, 1'b1, 1'b0); #1; chk("mp_wait", {30'h0, retire_valid}, 32'h0); tick();
      #1;
      chk("mp_retire_valid", {30'h0, retire_valid}, 32'h1);
      chk("mp_flush", flush, 1'b1);
      chk("mp_flush_pc", flush_pc, 32'h100);
      chk("mp_wb_en", retire_entry[0].wb_en, 1'b1);
      chk("mp_alloc_ready", alloc_ready, 1'b0);
      tick();
      #1;
      chk("mp_count", {27'h0, count}, 32'h0);
      chk("mp_empty", empty, 1'b1);

      // Exception at head, with a same-cycle allocation that must drop
      do_alloc(5'd9, 1'b1, 32'h200, 4'd0, 1'b1, 1'b0, 1'b1); tick();
      do_cmpl(4'd0, 1'b0, 1'b1); tick();
      alloc_valid = 1'b1;
      alloc_entry = '{dest_reg: 5'd3, wb_en: 1'b1, pc: 32'h204, mispred: 1'b0, exception: 1'b0};
      #1;
      chk("ex_retire_valid", {30'h0, retire_valid}, 32'h1);
      chk("ex_flush", flush, 1'b1);
      chk("ex_flush_pc", flush_pc, 32'h200);
      chk("ex_wb_en", retire_entry[0].wb_en, 1'b0);
      chk("ex_alloc_ready", alloc_ready, 1'b0);
      tick();
      #1;
      chk("ex_count", {27'h0, count}, 32'h0);
      chk("ex_alloc_idx", {28'h0, alloc_idx}, 32'h0);

      // Reset with 5 live entries, 2 ready
      for (int i = 0; i < 5; i++) begin
         do_alloc(5'(i), 1'b1, 32'h300 + 32'(4 * i), 4'(i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      do_cmpl(4'd1, 1'b0, 1'b0); tick();
      do_cmpl(4'd2, 1'b0, 1'b0); tick();
      #1; chk("pre_rst_count", {27'h0, count}, 32'd5);
      rst = 1'b1;
      #1;
      chk("midrst_retire_valid", {30'h0, retire_valid}, 32'h0);
      chk("midrst_flush", flush, 1'b0);
      chk("midrst_count", {27'h0, count}, 32'h0);
      tick();
      rst = 1'b0;
      #1;
      chk("postrst_count", {27'h0, count}, 32'h0);
      chk("postrst_retire_valid", {30'h0, retire_valid}, 32'h0);
      do_alloc(5'd1, 1'b1, 32'h400, 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
      #1;
      chk("postrst_alloc_count", {27'h0, count}, 32'd1);

      repeat (3) tick();
      chk("scoreboard_drained", sb.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
